// File: rtl/fft_pkg.sv
// Shared FFT datapath constants and helpers used by the butterfly, commutator
// and delay blocks.
package fft_pkg;

    localparam int FFT_WIDTH    = 16;
    localparam int FFT_CHANNELS = 2;

    // Bits needed to index 'value' distinct items (ceil(log2(value))).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Zero is promoted to one and anything past max_delay is pinned to it.
    function automatic int unsigned clamp_delay(input int unsigned delay,
                                                input int unsigned max_delay);
        if (delay == 0) begin
            return 1;
        end
        if (delay > max_delay) begin
            return max_delay;
        end
        return delay;
    endfunction

endpackage

// File: rtl/delay_tap_mux.sv
// N:1 tap selector over a flattened stage array; purely combinational.
module delay_tap_mux #(
    parameter int WIDTH_T = 33,
    parameter int N       = 16,
    parameter int SW      = 5
) (
    input  logic [N*WIDTH_T-1:0] taps,
    input  logic [SW-1:0]        sel,
    output logic [WIDTH_T-1:0]   tap
);

    always_comb begin
        tap = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SW'(i)) begin
                tap = taps[i*WIDTH_T +: WIDTH_T];
            end
        end
    end

endmodule

// File: rtl/prog_delay_line.sv
// Programmable multi-channel delay line: a shift register of valid-tagged
// stages with a runtime tap, stall-aware clock enable and synchronous flush.
module prog_delay_line
    import fft_pkg::*;
#(
    parameter int WIDTH     = FFT_WIDTH,
    parameter int CHANNELS  = FFT_CHANNELS,
    parameter int MAX_DELAY = 16,
    localparam int DW       = clog2(MAX_DELAY + 1)
) (
    input  logic                      clk,
    input  logic                      clr_n,
    input  logic                      flush,
    input  logic                      ce,
    input  logic [DW-1:0]             delay,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic                      out_valid,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      primed,
    output logic [DW-1:0]             fill
);

    localparam int WT = CHANNELS * WIDTH + 1;

    logic [WT-1:0]           stage [MAX_DELAY];
    logic [MAX_DELAY*WT-1:0] taps;
    logic [WT-1:0]           tap;
    logic [DW-1:0]           d_eff;
    logic [DW-1:0]           tap_sel;

    assign d_eff   = DW'(clamp_delay(32'(delay), MAX_DELAY));
    assign tap_sel = d_eff - DW'(1);

    // Each stage carries its valid bit in the MSB so it moves with the data.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < MAX_DELAY; i++) begin
                stage[i] <= '0;
            end
            fill <= '0;
        end else if (flush) begin
            for (int i = 0; i < MAX_DELAY; i++) begin
                stage[i] <= '0;
            end
            fill <= '0;
        end else if (ce) begin
            stage[0] <= {in_valid, in_data};
            for (int i = 1; i < MAX_DELAY; i++) begin
                stage[i] <= stage[i-1];
            end
            if (fill != DW'(MAX_DELAY)) begin
                fill <= fill + DW'(1);
            end
        end
    end

    always_comb begin
        taps = '0;
        for (int i = 0; i < MAX_DELAY; i++) begin
            taps[i*WT +: WT] = stage[i];
        end
    end

    delay_tap_mux #(
        .WIDTH_T (WT),
        .N       (MAX_DELAY),
        .SW      (DW)
    ) u_tap_mux (
        .taps (taps),
        .sel  (tap_sel),
        .tap  (tap)
    );

    assign {out_valid, out_data} = tap;
    assign primed                = (fill >= d_eff);

endmodule

// File: tb/tb_prog_delay_line.sv
// Directed bench for prog_delay_line (WIDTH=16, CHANNELS=2, MAX_DELAY=16).
module tb_prog_delay_line;

    localparam int W  = 16;
    localparam int CH = 2;
    localparam int MD = 16;
    localparam int DW = 5;

    logic            clk = 1'b0;
    logic            clr_n;
    logic            flush;
    logic            ce;
    logic [DW-1:0]   delay;
    logic            in_valid;
    logic [CH*W-1:0] in_data;
    logic            out_valid;
    logic [CH*W-1:0] out_data;
    logic            primed;
    logic [DW-1:0]   fill;

    int total  = 0;
    int passed = 0;

    prog_delay_line #(
        .WIDTH     (W),
        .CHANNELS  (CH),
        .MAX_DELAY (MD)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .flush     (flush),
        .ce        (ce),
        .delay     (delay),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .primed    (primed),
        .fill      (fill)
    );

    always #5 clk = ~clk;

    // Distinct re/im per sample so a channel slip shows up as a data error.
    function automatic logic [CH*W-1:0] mk(input int v);
        return {16'(16'hA000 + v), 16'(v)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic v, input logic [CH*W-1:0] d, input logic e);
        in_valid = v;
        in_data  = d;
        ce       = e;
        tick();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        ce    = 1'b0;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        clr_n    = 1'b0;
        flush    = 1'b0;
        ce       = 1'b0;
        delay    = 5'd4;
        in_valid = 1'b0;
        in_data  = '0;
        #3;
        check("reset_out", 64'({out_valid, out_data}), 64'd0);
        check("reset_fill_primed", 64'({fill, primed}), 64'd0);
        clr_n = 1'b1;
        tick();

        // Latency with delay=4: first sample emerges on the 4th enabled edge.
        for (int k = 1; k <= 6; k++) begin
            push(1'b1, mk(k), 1'b1);
            if (k == 3) begin
                check("lat_pre_valid", 64'(out_valid), 64'd0);
                check("lat_pre_primed", 64'({fill, primed}), 64'({5'd3, 1'b0}));
            end
            if (k == 4) begin
                check("lat_first", 64'({out_valid, out_data}), 64'({1'b1, mk(1)}));
                check("lat_primed", 64'({fill, primed}), 64'({5'd4, 1'b1}));
            end
            if (k == 6) begin
                check("lat_third", 64'({out_valid, out_data}), 64'({1'b1, mk(3)}));
            end
        end

        // Asynchronous reset mid-stream, between clock edges.
        clr_n = 1'b0;
        #1;
        check("async_rst_out", 64'({out_valid, out_data}), 64'd0);
        check("async_rst_fill", 64'({fill, primed}), 64'd0);
        #2;
        clr_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            push(1'b1, mk(100 + k), 1'b1);
            if (k < 4) begin
                check($sformatf("post_rst_invalid_%0d", k), 64'(out_valid), 64'd0);
            end else begin
                check("post_rst_first", 64'({out_valid, out_data}), 64'({1'b1, mk(101)}));
            end
        end

        // Stall: ce=0 edges change nothing; peek at stage 0 through delay=1.
        do_flush();
        delay = 5'd3;
        push(1'b1, mk(16'h0A), 1'b1);
        delay = 5'd1;
        for (int k = 0; k < 2; k++) begin
            push(1'b1, mk(16'h0EE), 1'b0);
            check($sformatf("stall_hold_%0d", k), 64'({out_valid, out_data}), 64'({1'b1, mk(16'h0A)}));
            check($sformatf("stall_fill_%0d", k), 64'(fill), 64'd1);
        end
        delay = 5'd3;
        push(1'b1, mk(16'h0B), 1'b1);
        check("stall_not_yet", 64'(out_valid), 64'd0);
        push(1'b1, mk(16'h0C), 1'b1);
        check("stall_a_out", 64'({out_valid, out_data}), 64'({1'b1, mk(16'h0A)}));
        check("stall_primed", 64'({fill, primed}), 64'({5'd3, 1'b1}));
        push(1'b1, mk(16'h0D), 1'b0);
        check("stall_a_held", 64'({out_valid, out_data}), 64'({1'b1, mk(16'h0A)}));
        push(1'b1, mk(16'h0D), 1'b1);
        check("stall_b_out", 64'({out_valid, out_data}), 64'({1'b1, mk(16'h0B)}));

        // Clamp low: delay=0 behaves as delay=1.
        do_flush();
        delay = 5'd0;
        push(1'b1, mk(7), 1'b1);
        check("clamp0_out", 64'({out_valid, out_data}), 64'({1'b1, mk(7)}));
        check("clamp0_primed", 64'(primed), 64'd1);

        // Clamp high and fill saturation: delay=21 acts as 16.
        do_flush();
        delay = 5'd21;
        for (int k = 1; k <= 40; k++) begin
            push(1'b1, mk(k), 1'b1);
            if (k == 15) begin
                check("clamp_hi_pre", 64'({out_valid, primed}), 64'd0);
            end
            if (k == 16) begin
                check("clamp_hi_first", 64'({out_valid, out_data}), 64'({1'b1, mk(1)}));
            end
        end
        check("sat_out", 64'({out_valid, out_data}), 64'({1'b1, mk(25)}));
        check("sat_fill", 64'({fill, primed}), 64'({5'd16, 1'b1}));
        delay = 5'd16;
        #1;
        check("sat_max_tap", 64'({out_valid, out_data, primed}), 64'({1'b1, mk(25), 1'b1}));

        // Flush while stalled, then flush and ce on the same edge.
        do_flush();
        delay = 5'd4;
        for (int k = 1; k <= 6; k++) begin
            push(1'b1, mk(50 + k), 1'b1);
        end
        flush = 1'b1;
        push(1'b1, mk(99), 1'b0);
        flush = 1'b0;
        check("flush_ce0_out", 64'({out_valid, out_data}), 64'd0);
        check("flush_ce0_fill", 64'(fill), 64'd0);
        push(1'b1, mk(60), 1'b1);
        push(1'b1, mk(61), 1'b1);
        flush = 1'b1;
        push(1'b1, mk(77), 1'b1);
        flush = 1'b0;
        delay = 5'd1;
        #1;
        check("flush_ce1_nocapture", 64'({out_valid, out_data}), 64'd0);
        check("flush_ce1_fill", 64'(fill), 64'd0);

        // Delay change mid-stream: after k pushes, tap d holds sample k-d+1.
        do_flush();
        delay = 5'd8;
        for (int k = 1; k <= 10; k++) begin
            push(1'b1, mk(k), 1'b1);
            if (k >= 8) begin
                check($sformatf("d8_k%0d", k), 64'({out_valid, out_data}), 64'({1'b1, mk(k - 7)}));
            end
        end
        delay = 5'd2;
        #1;
        check("shorten_jump", 64'({out_valid, out_data}), 64'({1'b1, mk(9)}));
        for (int k = 11; k <= 20; k++) begin
            push(1'b1, mk(k), 1'b1);
            if (k == 11 || k == 20) begin
                check($sformatf("d2_k%0d", k), 64'({out_valid, out_data}), 64'({1'b1, mk(k - 1)}));
            end
        end
        delay = 5'd8;
        #1;
        check("lengthen_reemit", 64'({out_valid, out_data}), 64'({1'b1, mk(13)}));
        check("lengthen_primed", 64'({fill, primed}), 64'({5'd16, 1'b1}));
        push(1'b1, mk(21), 1'b1);
        check("lengthen_next", 64'({out_valid, out_data}), 64'({1'b1, mk(14)}));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
